// File: rtl/uart_rcv.sv
// 8N1 asynchronous serial receiver: two-flop synchronizer, mid-bit sampling, break hold-off.
// Optional `UART_RCV_STOP_CHECK_EN drops frames whose stop sample is 0 instead of strobing them.
module uart_rcv #(
  parameter int CLKS_PER_BIT = 1302
) (
  input  logic       clk,
  input  logic       reset,
  output logic       full,
  output logic [7:0] parallel_out,
  input  logic       serial_in
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  logic             rx_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             cnt_zero_s;

  assign rx_s       = sync2_q;
  assign cnt_zero_s = (cnt_q == '0);
  assign shift_d    = {rx_s, shift_q[7:1]};

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM with registered strobe and byte outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      full         <= 1'b0;
      parallel_out <= 8'h00;
    end else begin
      full <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_M1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_zero_s) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q     <= FULL_M1;
              bit_idx_q <= 3'd0;
              state_q   <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_zero_s) begin
            shift_q   <= shift_d;
            cnt_q     <= FULL_M1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_zero_s) begin
`ifdef UART_RCV_STOP_CHECK_EN
            if (rx_s) begin
              full         <= 1'b1;
              parallel_out <= shift_q;
              state_q      <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_HIGH;
            end
`else
            full         <= 1'b1;
            parallel_out <= shift_q;
            state_q      <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // A held-low break must see the line return high before a new frame can start.
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// Scoreboard bench for uart_rcv at 16 clocks per bit.
module tb_uart_rcv;
  localparam int CPB = 16;
  localparam int LAT = 155; // drive-negedge of start bit to the negedge where full is seen

  logic       clk = 1'b0;
  logic       reset;
  logic       full;
  logic [7:0] parallel_out;
  logic       serial_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] last_byte = 8'h00;

  uart_rcv #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .full         (full),
    .parallel_out (parallel_out),
    .serial_in    (serial_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Every strobe must match the oldest pending expectation, on time when a due cycle is known.
  always @(negedge clk) begin
    if (full === 1'b1) begin
      chk("strobe_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("byte", 32'(parallel_out), 32'(e.data));
        if (e.due >= 0) chk("latency", 32'(cyc), 32'(e.due));
        last_byte = e.data;
      end
    end
  end

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Bit j of the frame (0 = start, 9 = stop) lasts p_even cycles for even j, p_odd otherwise.
  task automatic send_frame(input logic [7:0] d, input int p_even, input int p_odd, input bit timed);
    exp_t e;
    e.data = d;
    e.due  = timed ? cyc + LAT : -1;
    sb_q.push_back(e);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      serial_in = 1'b0;
      else if (j == 9) serial_in = 1'b1;
      else             serial_in = d[j-1];
      repeat ((j % 2 == 0) ? p_even : p_odd) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    chk({tag, "_hold"}, 32'(parallel_out), 32'(last_byte));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abort_byte;
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_pout", 32'(parallel_out), 32'h00);
    reset = 1'b0;
    idle(10);

    send_frame(8'hA5, CPB, CPB, 1'b1);
    idle(40);
    drain("single");
    chk("single_value", 32'(parallel_out), 32'hA5);

    send_frame(8'h00, CPB, CPB, 1'b1);
    send_frame(8'hFF, CPB, CPB, 1'b1);
    send_frame(8'h3C, CPB, CPB, 1'b1);
    idle(40);
    drain("b2b");

    serial_in = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    chk("false_start_pout", 32'(parallel_out), 32'h3C);
    send_frame(8'h55, CPB, CPB, 1'b1);
    idle(40);
    drain("after_false_start");

`ifndef UART_RCV_STOP_CHECK_EN
    begin
      exp_t e;
      e.data = 8'h00;
      e.due  = cyc + LAT;
      sb_q.push_back(e);
    end
`endif
    serial_in = 1'b0;
    repeat (400) @(negedge clk);
    idle(30);
    send_frame(8'h81, CPB, CPB, 1'b1);
    idle(40);
    drain("break");

    // Abort 0xC3 halfway through data bit 4.
    abort_byte = 8'hC3;
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      serial_in = abort_byte[k];
      repeat (CPB) @(negedge clk);
    end
    serial_in = abort_byte[4];
    repeat (CPB / 2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_full", 32'(full), 32'd0);
    chk("midreset_pout", 32'(parallel_out), 32'h00);
    last_byte = 8'h00;
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    idle(200);
    chk("midreset_quiet", 32'(parallel_out), 32'h00);
    send_frame(8'h5A, CPB, CPB, 1'b1);
    idle(40);
    drain("after_reset");

    // A sustained 15-cycle bit drifts over half a bit by bit 6, so the fast side alternates 15/16.
    send_frame(8'h96, 17, 17, 1'b0);
    idle(40);
    drain("slow_baud");
    send_frame(8'h96, 15, 16, 1'b0);
    idle(40);
    drain("fast_baud");

    chk("final_queue", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
